// File: rtl/evm_crypt_pkg.sv
// Shared types and stage transforms for the ballot-record cipher (encrypt and decrypt sides).
// Bit vectors are MSB-first: index 0 is the most significant bit.
package evm_crypt_pkg;

    localparam int BLK_W = 64;

    typedef logic [0:BLK_W-1] blk_t;

    typedef enum logic [3:0] {
        IDLE, K0, K1, K2, D0, D1, D2, D3, D4, DONE
    } state_t;

    typedef enum logic [1:0] {
        KS_IDLE, KS_ROT, KS_PRM, KS_TP
    } ks_state_t;

    // out[i] = x[(i+n) % 64]
    function automatic blk_t rotl(blk_t x, logic [5:0] n);
        blk_t       o;
        logic [5:0] j;
        o = '0;
        for (int i = 0; i < BLK_W; i++) begin
            j    = 6'(i) + n;
            o[i] = x[j];
        end
        return o;
    endfunction

    // Bijective only for odd mult; truncation to 6 bits is the mod 64.
    function automatic blk_t perm_map(blk_t x, int mult);
        blk_t o;
        o = '0;
        for (int i = 0; i < BLK_W; i++)
            o[6'(i * mult)] = x[i];
        return o;
    endfunction

    function automatic blk_t transpose(blk_t x);
        blk_t o;
        o = '0;
        for (int i = 0; i < BLK_W; i++)
            o[8 * (i % 8) + i / 8] = x[i];
        return o;
    endfunction

    function automatic blk_t mix_fwd(blk_t x, logic kb);
        blk_t o;
        o    = '0;
        o[0] = x[0] ^ kb;
        for (int i = 1; i < BLK_W; i++)
            o[i] = x[i] ^ x[i-1];
        return o;
    endfunction

endpackage

// File: rtl/evm_key_sched.sv
// Key schedule sequencer: rotate, permute, transpose, one step per clock after start.
// With KEY_CACHE_EN defined, a repeated master key reuses the held schedule (hit) and skips the run.
module evm_key_sched import evm_crypt_pkg::*; #(
    parameter int KEY_ROT   = 1,
    parameter int PERM_MULT = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  blk_t key,
    output logic hit,
    output logic done,
    output blk_t k
);
    localparam logic [5:0] ROT = 6'(KEY_ROT);

    ks_state_t state, state_nx;
    logic      run;

`ifdef KEY_CACHE_EN
    blk_t cache_key;
    logic cache_vld;

    assign hit = start && cache_vld && (key == cache_key);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_key <= '0;
            cache_vld <= 1'b0;
        end else if (run) begin
            cache_key <= key;
            cache_vld <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign run  = start && !hit;
    assign done = (state == KS_TP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= KS_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            KS_IDLE: if (run) state_nx = KS_ROT;
            KS_ROT:  state_nx = KS_PRM;
            KS_PRM:  state_nx = KS_TP;
            KS_TP:   state_nx = KS_IDLE;
            default: state_nx = KS_IDLE;
        endcase
    end

    // k holds the raw key during KS_ROT and the finished schedule once back in KS_IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else begin
            case (state)
                KS_IDLE: if (run) k <= key;
                KS_ROT:  k <= rotl(k, ROT);
                KS_PRM:  k <= perm_map(k, PERM_MULT);
                KS_TP:   k <= transpose(k);
                default: k <= k;
            endcase
        end
    end

endmodule

// File: rtl/evm_encrypter.sv
// Ballot-record encrypter: one 64-bit block per transaction, one stage per clock.
// Optional KEY_CACHE_EN skips the key schedule when the master key repeats.
module evm_encrypter import evm_crypt_pkg::*; #(
    parameter int KEY_ROT   = 1,
    parameter int PERM_MULT = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  blk_t data_in,
    input  blk_t round_key,
    output logic out_valid,
    input  logic out_ready,
    output blk_t data_out,
    output logic busy
);
    state_t state, state_nx;
    blk_t   data_reg;
    blk_t   res_reg;
    blk_t   k;
    logic   accept;
    logic   ks_hit;
    logic   ks_done;

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign data_out  = res_reg;

    evm_key_sched #(
        .KEY_ROT   (KEY_ROT),
        .PERM_MULT (PERM_MULT)
    ) u_key_sched (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .key   (round_key),
        .hit   (ks_hit),
        .done  (ks_done),
        .k     (k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = ks_hit ? D0 : K0;
            K0:      state_nx = K1;
            K1:      state_nx = K2;
            K2:      if (ks_done) state_nx = D0;
            D0:      state_nx = D1;
            D1:      state_nx = D2;
            D2:      state_nx = D3;
            D3:      state_nx = D4;
            D4:      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Result lives in its own register so intermediate stages never appear on data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            res_reg  <= '0;
        end else begin
            case (state)
                IDLE:    if (in_valid) data_reg <= data_in;
                D0:      data_reg <= rotl(data_reg, k[58:63]);
                D1:      data_reg <= transpose(data_reg);
                D2:      data_reg <= data_reg ^ k;
                D3:      data_reg <= perm_map(data_reg, PERM_MULT);
                D4:      res_reg  <= mix_fwd(data_reg, k[BLK_W-1]);
                default: data_reg <= data_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_evm_encrypter.sv
// Self-checking bench for evm_encrypter: directed vectors, stall, mid-run reset, random blocks.
// Reference model works on plain 64-bit words (MSB-first = bit 63); honours KEY_CACHE_EN.
module tb_evm_encrypter;
    localparam int KEY_ROT   = 1;
    localparam int PERM_MULT = 13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_in = '0;
    logic [63:0] round_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] data_out;
    logic        busy;

    logic        rnd_stall = 1'b0;
    logic        ready_force = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [63:0] ct;
        logic [63:0] key;
        logic [63:0] pt;
        int          acc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    logic [63:0] cache_key = '0;
    logic        cache_vld = 1'b0;
    logic        prev_ov = 1'b0;

    evm_encrypter #(.KEY_ROT(KEY_ROT), .PERM_MULT(PERM_MULT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rnd_stall ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_rotl(logic [63:0] x, int n);
        logic [127:0] d;
        d = {x, x} << n;
        return d[127:64];
    endfunction

    // 8x8 bit matrix, one byte per row, transposed
    function automatic logic [63:0] m_tp(logic [63:0] x);
        logic [7:0] row [8];
        logic [7:0] nrow[8];
        for (int r = 0; r < 8; r++) row[r] = x[63-8*r -: 8];
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                nrow[r][7-c] = row[c][7-r];
        return {nrow[0], nrow[1], nrow[2], nrow[3], nrow[4], nrow[5], nrow[6], nrow[7]};
    endfunction

    function automatic logic [63:0] m_perm(logic [63:0] x, logic inv);
        logic [63:0] o;
        int          dst;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            dst = (i * PERM_MULT) % 64;
            if (inv) o[63-i]   = x[63-dst];
            else     o[63-dst] = x[63-i];
        end
        return o;
    endfunction

    function automatic logic [63:0] m_sched(logic [63:0] key);
        return m_tp(m_perm(m_rotl(key, KEY_ROT), 1'b0));
    endfunction

    function automatic logic [63:0] m_enc(logic [63:0] key, logic [63:0] d);
        logic [63:0] kk, x;
        kk = m_sched(key);
        x  = m_rotl(d, int'(kk[5:0]));
        x  = m_tp(x) ^ kk;
        x  = m_perm(x, 1'b0);
        return x ^ {kk[0], x[63:1]};
    endfunction

    function automatic logic [63:0] m_dec(logic [63:0] key, logic [63:0] c);
        logic [63:0] kk, x;
        kk    = m_sched(key);
        x[63] = c[63] ^ kk[0];
        for (int j = 62; j >= 0; j--) x[j] = c[j] ^ x[j+1];
        x = m_perm(x, 1'b1) ^ kk;
        x = m_tp(x);
        return m_rotl(x, (64 - int'(kk[5:0])) % 64);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        logic hit;
        if (!rst_n) begin
            exp_q.delete();
            cache_vld = 1'b0;
            prev_ov   = 1'b0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_data_out", data_out, 0);
        end else begin
            chk("busy_vs_ready", busy, !in_ready);
            if (out_valid) begin
                chk("ready_in_done", in_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    if (!prev_ov)
                        chk("latency", 64'(cyc - exp_q[0].acc + 1), 64'(exp_q[0].lat));
                    chk("ciphertext", data_out, exp_q[0].ct);
                    if (out_ready) begin
                        chk("roundtrip", m_dec(exp_q[0].key, data_out), exp_q[0].pt);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                hit = 1'b0;
`ifdef KEY_CACHE_EN
                hit = cache_vld && (round_key == cache_key);
                cache_key = round_key;
                cache_vld = 1'b1;
`endif
                e.ct  = m_enc(round_key, data_in);
                e.key = round_key;
                e.pt  = data_in;
                e.acc = cyc + 1;
                e.lat = hit ? 6 : 9;
                exp_q.push_back(e);
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [63:0] k, input logic [63:0] d);
        int t = 0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        round_key = k;
        data_in   = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                chk("accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        round_key = {$urandom, $urandom};
        data_in   = {$urandom, $urandom};
    endtask

    task automatic drain();
        int t = 0;
        forever begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && in_ready) break;
            t++;
            if (t > 2000) begin
                chk("drain_timeout", 64'(exp_q.size()), 0);
                break;
            end
        end
    endtask

    logic [63:0] rk, rd, last_key;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // model pins from hand-worked vectors
        chk("pin_zero", m_enc(64'h0, 64'h0), 64'h0);
        chk("pin_ones_key", m_enc('1, 64'h0), 64'h0);
        chk("pin_msb", m_enc(64'h0, 64'h8000_0000_0000_0000), 64'hC000_0000_0000_0000);

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        send(64'h0, 64'h0);                           drain();
        send('1, 64'h0);                              drain();
        send(64'h0, 64'h8000_0000_0000_0000);         drain();
        send(64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0BAD_F00D); drain();

        // stall in DONE for 5 cycles while offering a new block
        ready_force = 1'b0;
        send(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        for (int t = 0; t < 50 && !out_valid; t++) @(posedge clk);
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            data_in   = {$urandom, $urandom};
            round_key = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        in_valid    = 1'b0;
        ready_force = 1'b1;
        drain();

        // reset in D2: 5 edges after the accept edge
        send(64'hCAFE_F00D_1234_5678, 64'h0F0F_0F0F_F0F0_F0F0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_data_out", data_out, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        send(64'hCAFE_F00D_1234_5678, 64'h0F0F_0F0F_F0F0_F0F0); drain();

        // random blocks with random consumer stalls; some keys repeat
        rnd_stall = 1'b1;
        last_key  = 64'h0;
        for (int n = 0; n < 1000; n++) begin
            rk = ($urandom_range(0, 2) == 0) ? last_key : {$urandom, $urandom};
            rd = {$urandom, $urandom};
            last_key = rk;
            send(rk, rd);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
